// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, types and helpers for the vectoring-mode CORDIC pipeline
// Ports: none (package).
package cordic_pkg;

   localparam int DEFAULT_DATA_WIDTH = 15;
   localparam int ANGLE_PI           = 2 ** (DEFAULT_DATA_WIDTH - 1);
   localparam int CORDIC_ITER        = 12;
   // One initial quadrant-fold stage plus one register per iteration.
   localparam int CORDIC_DELAY       = 1 + CORDIC_ITER;

   typedef struct packed {
      logic valid;
      logic sign;
   } tap_t;

   // round(0.607253 * 2^(width-1)) in integer arithmetic so it stays an
   // elaboration-time constant without real numbers.
   function automatic int calc_k_q(input int width);
      longint scaled;
      scaled = longint'(607253) * (longint'(1) << (width - 1));
      return int'((scaled + longint'(500000)) / longint'(1000000));
   endfunction

endpackage

// File: rtl/cordic_final_stage_if.sv
// rtl/cordic_final_stage_if.sv - sample/result bundle between the CORDIC iterations and the final stage
// Ports: master = upstream pipeline (drives entry/sample, reads results)
//        slave  = cordic_final_stage (reads entry/sample, drives results)
interface cordic_final_stage_if
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic                  entry_valid;
   logic                  sign_in;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] x_in;
   logic [DATA_WIDTH-1:0] theta_in;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] mag_out;
   logic [DATA_WIDTH-1:0] phase_out;
   logic                  align_err;
   logic                  neg_err;

   modport master (
      output entry_valid, sign_in, in_valid, x_in, theta_in,
      input  out_valid, mag_out, phase_out, align_err, neg_err
   );

   modport slave (
      input  entry_valid, sign_in, in_valid, x_in, theta_in,
      output out_valid, mag_out, phase_out, align_err, neg_err
   );

endinterface

// File: rtl/cordic_sign_delay.sv
// rtl/cordic_sign_delay.sv - DEPTH-deep shift register carrying {valid, sign} alongside the CORDIC pipeline
// Ports: clk, rst (sync, active-high); valid_in/sign_in sampled every cycle;
//        valid_out/sign_out = tap at depth DEPTH.
module cordic_sign_delay
   import cordic_pkg::*;
#(
   parameter int DEPTH = CORDIC_DELAY
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_in,
   input  logic sign_in,
   output logic valid_out,
   output logic sign_out
);

   tap_t [DEPTH-1:0] line_q;
   tap_t [DEPTH-1:0] line_d;

   // Loop form keeps DEPTH=1 legal (no zero-width slices).
   always_comb begin
      line_d    = line_q;
      line_d[0] = '{valid: valid_in, sign: sign_in};
      for (int i = 1; i < DEPTH; i++) begin
         line_d[i] = line_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign valid_out = line_q[DEPTH-1].valid;
   assign sign_out  = line_q[DEPTH-1].sign;

endmodule

// File: rtl/cordic_final_stage.sv
// rtl/cordic_final_stage.sv - gain compensation and quadrant correction at the CORDIC output
// Ports: clk, rst (sync, active-high);
//        bus (slave): entry_valid/sign_in at pipeline entry, in_valid/x_in/theta_in
//        from the last iteration, out_valid/mag_out/phase_out results,
//        align_err/neg_err sticky error flags.
module cordic_final_stage
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DELAY      = CORDIC_DELAY,
   parameter int K_Q        = calc_k_q(DATA_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   cordic_final_stage_if.slave  bus
);

   localparam int                    PW    = 2 * DATA_WIDTH;
   localparam logic [PW-1:0]         K_Q_W = PW'(K_Q);
   localparam logic [DATA_WIDTH-1:0] PI_W  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

   logic d_valid;
   logic d_sign;
   logic x_neg;

   logic [PW-1:0]         prod_q, prod_d;
   logic [DATA_WIDTH-1:0] phase1_q, phase1_d;
   logic                  v1_q, v1_d;
   logic [DATA_WIDTH-1:0] mag_q, mag_d;
   logic [DATA_WIDTH-1:0] phase_q, phase_d;
   logic                  out_valid_q, out_valid_d;
   logic                  align_err_q, align_err_d;
   logic                  neg_err_q, neg_err_d;

   cordic_sign_delay #(
      .DEPTH (DELAY)
   ) u_sign_delay (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (bus.entry_valid),
      .sign_in   (bus.sign_in),
      .valid_out (d_valid),
      .sign_out  (d_sign)
   );

   assign x_neg = bus.x_in[DATA_WIDTH-1];

   // Stage 1: gain multiply and quadrant fold-back; data holds when idle.
   always_comb begin
      prod_d      = prod_q;
      phase1_d    = phase1_q;
      neg_err_d   = neg_err_q;
      v1_d        = bus.in_valid;
      // Mismatch is flagged but the sample still goes through with d_sign.
      align_err_d = align_err_q | (bus.in_valid ^ d_valid);
      if (bus.in_valid) begin
         prod_d    = x_neg ? '0 : PW'(bus.x_in) * K_Q_W;
         // Original X was negative: mirror the angle about pi/2; +pi wraps to -pi.
         phase1_d  = d_sign ? (PI_W - bus.theta_in) : bus.theta_in;
         neg_err_d = neg_err_q | x_neg;
      end
   end

   // Stage 2: rescale; outputs hold their last result between samples.
   always_comb begin
      mag_d       = mag_q;
      phase_d     = phase_q;
      out_valid_d = v1_q;
      if (v1_q) begin
         // K_Q < 2^(DATA_WIDTH-1) keeps the MSB of the shifted product clear.
         mag_d   = DATA_WIDTH'(prod_q >> (DATA_WIDTH - 1));
         phase_d = phase1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q      <= '0;
         phase1_q    <= '0;
         v1_q        <= 1'b0;
         mag_q       <= '0;
         phase_q     <= '0;
         out_valid_q <= 1'b0;
         align_err_q <= 1'b0;
         neg_err_q   <= 1'b0;
      end else begin
         prod_q      <= prod_d;
         phase1_q    <= phase1_d;
         v1_q        <= v1_d;
         mag_q       <= mag_d;
         phase_q     <= phase_d;
         out_valid_q <= out_valid_d;
         align_err_q <= align_err_d;
         neg_err_q   <= neg_err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.mag_out   = mag_q;
   assign bus.phase_out = phase_q;
   assign bus.align_err = align_err_q;
   assign bus.neg_err   = neg_err_q;

endmodule
